// File: rtl/ascon_ti_pkg.sv
// Shared constants, types and helpers for the three-share Ascon permutation controller.
// Lane x0 sits at the top of the 320-bit state word, lane x4 at the bottom.
package ascon_ti_pkg;

    localparam int unsigned ROUNDS_MAX = 12;
    localparam int unsigned LANE_W     = 64;
    localparam int unsigned NUM_LANES  = 5;
    localparam int unsigned STATE_W    = 320;

    localparam int unsigned LANE_LO [NUM_LANES] = '{256, 192, 128, 64, 0};
    localparam int unsigned ROT_A   [NUM_LANES] = '{19, 61, 1, 10, 7};
    localparam int unsigned ROT_B   [NUM_LANES] = '{28, 39, 6, 17, 41};

    // Round constant lands in the low byte of lane x2
    localparam int unsigned RC_LO = 128;

    localparam logic [7:0] RC_TAB [ROUNDS_MAX] = '{
        8'hf0, 8'he1, 8'hd2, 8'hc3, 8'hb4, 8'ha5,
        8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic [LANE_W-1:0] ror(input logic [LANE_W-1:0] x, input int unsigned n);
        return (x >> n) | (x << (LANE_W - n));
    endfunction

    function automatic logic [7:0] rc_lookup(input logic [3:0] idx);
        logic [7:0] rc;
        rc = 8'h00;
        for (int unsigned i = 0; i < ROUNDS_MAX; i++) begin
            if (idx == 4'(i)) rc = RC_TAB[i];
        end
        return rc;
    endfunction

endpackage

// File: rtl/ascon_ti_lin_layer.sv
// Ascon linear diffusion layer for one share; purely combinational.
// Linear, so it is applied to each share independently without recombining.
module ascon_ti_lin_layer
    import ascon_ti_pkg::*;
(
    input  logic [STATE_W-1:0] x_i,
    output logic [STATE_W-1:0] y_o
);

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        logic [LANE_W-1:0] lane;
        assign lane = x_i[LANE_LO[l] +: LANE_W];
        assign y_o[LANE_LO[l] +: LANE_W] = lane ^ ror(lane, ROT_A[l]) ^ ror(lane, ROT_B[l]);
    end

endmodule

// File: rtl/ascon_ti_perm_ctrl.sv
// Iterative three-share Ascon permutation: share registers, round constant, external TI S-box, L.
// Optional ASCON_TI_REMASK_EN adds rnd_in_i and refreshes the shares after every round.
module ascon_ti_perm_ctrl
    import ascon_ti_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic [3:0]         rounds_i,
    input  logic [STATE_W-1:0] st_in_0_i,
    input  logic [STATE_W-1:0] st_in_1_i,
    input  logic [STATE_W-1:0] st_in_2_i,
    output logic [STATE_W-1:0] sb_x_0_o,
    output logic [STATE_W-1:0] sb_x_1_o,
    output logic [STATE_W-1:0] sb_x_2_o,
    input  logic [STATE_W-1:0] sb_y_0_i,
    input  logic [STATE_W-1:0] sb_y_1_i,
    input  logic [STATE_W-1:0] sb_y_2_i,
    output logic [STATE_W-1:0] st_out_0_o,
    output logic [STATE_W-1:0] st_out_1_o,
    output logic [STATE_W-1:0] st_out_2_o,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic               busy_o
`ifdef ASCON_TI_REMASK_EN
    ,
    input  logic [2*STATE_W-1:0] rnd_in_i
`endif
);

    state_e             state_q, state_d;
    logic [STATE_W-1:0] sh0_q, sh0_d;
    logic [STATE_W-1:0] sh1_q, sh1_d;
    logic [STATE_W-1:0] sh2_q, sh2_d;
    logic [3:0]         rc_idx_q, rc_idx_d;

    logic [STATE_W-1:0] rc_word;
    logic [STATE_W-1:0] lin0, lin1, lin2;
    logic [STATE_W-1:0] mask0, mask1, mask2;
    logic               rounds_ok;

    assign rounds_ok = (rounds_i != 4'd0) && (rounds_i <= 4'(ROUNDS_MAX));

    // Constant only touches share 0, and only while a round is in flight
    always_comb begin
        rc_word = '0;
        if (state_q == RUN) rc_word[RC_LO +: 8] = rc_lookup(rc_idx_q);
    end

    assign sb_x_0_o = sh0_q ^ rc_word;
    assign sb_x_1_o = sh1_q;
    assign sb_x_2_o = sh2_q;

    ascon_ti_lin_layer u_lin0 (.x_i(sb_y_0_i), .y_o(lin0));
    ascon_ti_lin_layer u_lin1 (.x_i(sb_y_1_i), .y_o(lin1));
    ascon_ti_lin_layer u_lin2 (.x_i(sb_y_2_i), .y_o(lin2));

`ifdef ASCON_TI_REMASK_EN
    // Three masks XOR to zero, so the unmasked value is untouched
    assign mask0 = rnd_in_i[STATE_W-1:0];
    assign mask1 = rnd_in_i[2*STATE_W-1:STATE_W];
    assign mask2 = mask0 ^ mask1;
`else
    assign mask0 = '0;
    assign mask1 = '0;
    assign mask2 = '0;
`endif

    always_comb begin
        state_d  = state_q;
        sh0_d    = sh0_q;
        sh1_d    = sh1_q;
        sh2_d    = sh2_q;
        rc_idx_d = rc_idx_q;
        case (state_q)
            IDLE: begin
                if (start_i && rounds_ok) begin
                    sh0_d    = st_in_0_i;
                    sh1_d    = st_in_1_i;
                    sh2_d    = st_in_2_i;
                    rc_idx_d = 4'(ROUNDS_MAX) - rounds_i;
                    state_d  = RUN;
                end
            end
            RUN: begin
                sh0_d    = lin0 ^ mask0;
                sh1_d    = lin1 ^ mask1;
                sh2_d    = lin2 ^ mask2;
                rc_idx_d = rc_idx_q + 4'd1;
                if (rc_idx_q == 4'(ROUNDS_MAX - 1)) state_d = DONE;
            end
            DONE: begin
                if (out_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            sh0_q    <= '0;
            sh1_q    <= '0;
            sh2_q    <= '0;
            rc_idx_q <= '0;
        end else begin
            state_q  <= state_d;
            sh0_q    <= sh0_d;
            sh1_q    <= sh1_d;
            sh2_q    <= sh2_d;
            rc_idx_q <= rc_idx_d;
        end
    end

    assign st_out_0_o  = sh0_q;
    assign st_out_1_o  = sh1_q;
    assign st_out_2_o  = sh2_q;
    assign out_valid_o = (state_q == DONE);
    assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_ascon_ti_perm_ctrl.sv
// Directed bench for ascon_ti_perm_ctrl with an attached three-share TI S-box and reference models.
module tb_ascon_ti_perm_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, start, out_ready, out_valid, busy;
    logic [3:0]   rounds;
    logic [319:0] st_in_0, st_in_1, st_in_2;
    logic [319:0] sb_x_0, sb_x_1, sb_x_2;
    logic [319:0] sb_y_0, sb_y_1, sb_y_2;
    logic [319:0] st_out_0, st_out_1, st_out_2;
    logic [959:0] sb_y_all;

    int checks = 0;
    int errors = 0;

    localparam logic [319:0] IV = {64'h80400c0600000000, 256'h0};

`ifdef ASCON_TI_REMASK_EN
    logic [639:0] rnd_in;
`endif

    ascon_ti_perm_ctrl dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .rounds_i    (rounds),
        .st_in_0_i   (st_in_0),
        .st_in_1_i   (st_in_1),
        .st_in_2_i   (st_in_2),
        .sb_x_0_o    (sb_x_0),
        .sb_x_1_o    (sb_x_1),
        .sb_x_2_o    (sb_x_2),
        .sb_y_0_i    (sb_y_0),
        .sb_y_1_i    (sb_y_1),
        .sb_y_2_i    (sb_y_2),
        .st_out_0_o  (st_out_0),
        .st_out_1_o  (st_out_1),
        .st_out_2_o  (st_out_2),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .busy_o      (busy)
`ifdef ASCON_TI_REMASK_EN
        ,
        .rnd_in_i    (rnd_in)
`endif
    );

    function automatic logic [7:0] rc_tb(input int i);
        case (i)
            0: return 8'hf0;  1: return 8'he1;  2: return 8'hd2;  3: return 8'hc3;
            4: return 8'hb4;  5: return 8'ha5;  6: return 8'h96;  7: return 8'h87;
            8: return 8'h78;  9: return 8'h69; 10: return 8'h5a; 11: return 8'h4b;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [63:0] ror64(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic logic [319:0] lin_tb(input logic [319:0] s);
        logic [63:0] x0, x1, x2, x3, x4;
        {x0, x1, x2, x3, x4} = s;
        x0 = x0 ^ ror64(x0, 19) ^ ror64(x0, 28);
        x1 = x1 ^ ror64(x1, 61) ^ ror64(x1, 39);
        x2 = x2 ^ ror64(x2, 1)  ^ ror64(x2, 6);
        x3 = x3 ^ ror64(x3, 10) ^ ror64(x3, 17);
        x4 = x4 ^ ror64(x4, 7)  ^ ror64(x4, 41);
        return {x0, x1, x2, x3, x4};
    endfunction

    function automatic logic [319:0] sbox_plain(input logic [319:0] s);
        logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
        {x0, x1, x2, x3, x4} = s;
        x0 ^= x4; x4 ^= x3; x2 ^= x1;
        t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
        x0 ^= t1; x1 ^= t2; x2 ^= t3; x3 ^= t4; x4 ^= t0;
        x1 ^= x0; x0 ^= x4; x3 ^= x2; x2 = ~x2;
        return {x0, x1, x2, x3, x4};
    endfunction

    function automatic logic [319:0] perm_plain(input logic [319:0] s_in, input int r);
        logic [319:0] s;
        s = s_in;
        for (int i = 12 - r; i < 12; i++) begin
            s[135:128] ^= rc_tb(i);
            s = lin_tb(sbox_plain(s));
        end
        return s;
    endfunction

    // Threshold S-box: linear steps share-wise, each AND via the 3-share product sharing
    function automatic logic [959:0] ti_sbox(input logic [319:0] s0, input logic [319:0] s1,
                                             input logic [319:0] s2);
        logic [319:0] in_s [3];
        logic [63:0]  x [3][5];
        logic [63:0]  y [3][5];
        logic [63:0]  a [3];
        logic [63:0]  b [3];
        logic [63:0]  z [3];
        in_s[0] = s0; in_s[1] = s1; in_s[2] = s2;
        for (int k = 0; k < 3; k++)
            for (int l = 0; l < 5; l++)
                x[k][l] = in_s[k][319 - 64*l -: 64];
        for (int k = 0; k < 3; k++) begin
            x[k][0] ^= x[k][4]; x[k][4] ^= x[k][3]; x[k][2] ^= x[k][1];
        end
        for (int i = 0; i < 5; i++) begin
            for (int k = 0; k < 3; k++) begin
                a[k] = x[k][(i + 1) % 5];
                b[k] = x[k][(i + 2) % 5];
            end
            z[0] = (a[1] & b[1]) ^ (a[1] & b[2]) ^ (a[2] & b[1]);
            z[1] = (a[2] & b[2]) ^ (a[2] & b[0]) ^ (a[0] & b[2]);
            z[2] = (a[0] & b[0]) ^ (a[0] & b[1]) ^ (a[1] & b[0]);
            for (int k = 0; k < 3; k++) y[k][i] = x[k][i] ^ b[k] ^ z[k];
        end
        for (int k = 0; k < 3; k++) begin
            y[k][1] ^= y[k][0]; y[k][0] ^= y[k][4]; y[k][3] ^= y[k][2];
        end
        y[0][2] = ~y[0][2];
        return {y[0][0], y[0][1], y[0][2], y[0][3], y[0][4],
                y[1][0], y[1][1], y[1][2], y[1][3], y[1][4],
                y[2][0], y[2][1], y[2][2], y[2][3], y[2][4]};
    endfunction

    function automatic logic [959:0] ti_perm(input logic [319:0] a0, input logic [319:0] a1,
                                             input logic [319:0] a2, input int r);
        logic [319:0] s0, s1, s2;
        logic [959:0] y;
        s0 = a0; s1 = a1; s2 = a2;
        for (int i = 12 - r; i < 12; i++) begin
            s0[135:128] ^= rc_tb(i);
            y  = ti_sbox(s0, s1, s2);
            s0 = lin_tb(y[959:640]);
            s1 = lin_tb(y[639:320]);
            s2 = lin_tb(y[319:0]);
        end
        return {s0, s1, s2};
    endfunction

    function automatic logic [319:0] rand320();
        logic [319:0] v;
        for (int i = 0; i < 10; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    assign sb_y_all = ti_sbox(sb_x_0, sb_x_1, sb_x_2);
    assign sb_y_0   = sb_y_all[959:640];
    assign sb_y_1   = sb_y_all[639:320];
    assign sb_y_2   = sb_y_all[319:0];

`ifdef ASCON_TI_REMASK_EN
    always @(negedge clk) rnd_in = {rand320(), rand320()};
`endif

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issues start, waits for out_valid, checks latency, constant injection and result
    task automatic run_op(input int r, input logic [319:0] a0, input logic [319:0] a1,
                          input logic [319:0] a2, input bit poke_start);
        logic [959:0] ti_exp;
        int n;
        st_in_0 = a0; st_in_1 = a1; st_in_2 = a2;
        rounds  = 4'(r);
        start   = 1'b1;
        step();
        n = 1;
        start = 1'b0;
        chk("busy_run", busy, 1'b1);
        chk("rc_inject", sb_x_0[135:128], a0[135:128] ^ rc_tb(12 - r));
        while (!out_valid && n < 40) begin
            if (poke_start && n == 2) begin
                start   = 1'b1;
                rounds  = 4'd12;
                st_in_0 = ~a0;
            end
            step();
            n++;
            start = 1'b0;
            if (poke_start && n == 3) chk("busy_poke", busy, 1'b1);
        end
        chk("latency", n, r + 1);
        ti_exp = ti_perm(a0, a1, a2, r);
        chk("unmasked", st_out_0 ^ st_out_1 ^ st_out_2, perm_plain(a0 ^ a1 ^ a2, r));
`ifdef ASCON_TI_REMASK_EN
        chk("share1_remasked", st_out_1 !== ti_exp[639:320], 1'b1);
`else
        chk("share0", st_out_0, ti_exp[959:640]);
        chk("share1", st_out_1, ti_exp[639:320]);
`endif
    endtask

    task automatic ack();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("ack_idle", busy, 1'b0);
    endtask

    initial begin
        logic [319:0] r1, r2, plain;
        rst = 1'b1; start = 1'b0; out_ready = 1'b0; rounds = 4'd0;
        st_in_0 = '0; st_in_1 = '0; st_in_2 = '0;
        step();
        step();
        chk("rst_busy", busy, 1'b0);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_share0", st_out_0, 320'h0);
        chk("rst_sbx0", sb_x_0, 320'h0);
        rst = 1'b0;

        st_in_0 = IV; st_in_1 = rand320(); st_in_2 = rand320();
        rounds = 4'd0; start = 1'b1;
        step();
        chk("ill0_busy", busy, 1'b0);
        chk("ill0_share0", st_out_0, 320'h0);
        rounds = 4'd13;
        step();
        chk("ill13_busy", busy, 1'b0);
        chk("ill13_share1", st_out_1, 320'h0);
        chk("ill13_valid", out_valid, 1'b0);
        start = 1'b0;

        run_op(12, IV, 320'h0, 320'h0, 1'b0);
        plain = perm_plain(IV, 12);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_valid", out_valid, 1'b1);
            chk("bp_hold", st_out_0 ^ st_out_1 ^ st_out_2, plain);
        end
        out_ready = 1'b1; start = 1'b1; rounds = 4'd12;
        step();
        out_ready = 1'b0; start = 1'b0;
        chk("hs_valid", out_valid, 1'b0);
        chk("hs_busy", busy, 1'b0);
        step();
        chk("hs_start_ignored", busy, 1'b0);

        r1 = rand320(); r2 = rand320();
        run_op(6, IV ^ r1 ^ r2, r1, r2, 1'b0);
        ack();
        r1 = rand320(); r2 = rand320();
        run_op(8, IV ^ r1 ^ r2, r1, r2, 1'b1);
        ack();

        r1 = rand320(); r2 = rand320();
        st_in_0 = IV ^ r1 ^ r2; st_in_1 = r1; st_in_2 = r2;
        rounds = 4'd12; start = 1'b1;
        step();
        start = 1'b0;
        step(); step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mrst_busy", busy, 1'b0);
        chk("mrst_valid", out_valid, 1'b0);
        chk("mrst_share0", st_out_0, 320'h0);
        chk("mrst_share2", st_out_2, 320'h0);
        r1 = rand320(); r2 = rand320();
        run_op(12, IV ^ r1 ^ r2, r1, r2, 1'b0);
        ack();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
